// File: rtl/sorted_dedup_stream_pkg.sv
// sorted_dedup_pkg: shared FSM state type and run-count helper for sorted_dedup_stream.
package sorted_dedup_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int unsigned sat_inc(int unsigned r, int unsigned mx);
    return (r >= mx) ? mx : r + 1;
  endfunction
endpackage

// File: rtl/sorted_dedup_stream_if.sv
// sorted_dedup_stream_if: valid/ready element stream from host loader into the dedup block.
interface sorted_dedup_stream_if #(parameter int DATA_W = 32);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  modport master(output valid, data, input ready);
  modport slave(input valid, data, output ready);
endinterface

// File: rtl/sorted_dedup_stream_ram.sv
// dedup_buf_ram: survivor buffer, one write port and one registered read port with zero-masking.
module dedup_buf_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic              re_i,
  input  logic [AW-1:0]     ra_i,
  output logic [DATA_W-1:0] rd_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;
  always_ff @(posedge clk) if (we_i) mem_q[wa_i] <= wd_i;
  // Entries at or beyond k read as zero so stale contents never leak out.
  always_ff @(posedge clk) rd_q <= rst ? '0 : (re_i ? mem_q[ra_i] : '0);
  assign rd_o = rd_q;
endmodule

// File: rtl/sorted_dedup_stream.sv
// sorted_dedup_stream: keeps at most keep_n copies of each value from a sorted stream,
// compacting survivors into a buffer and flagging out-of-order input.
module sorted_dedup_stream
  import sorted_dedup_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = $clog2(DEPTH + 1),
  parameter int KEEP_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [CNT_W-1:0]    len_i,
  input  logic [KEEP_W-1:0]   keep_n_i,
  sorted_dedup_stream_if.slave in_if,
  input  logic [CNT_W-1:0]    rd_addr_i,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    k_o,
  output logic                err_unsorted_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam int unsigned RUN_MAX = 2 ** KEEP_W - 1;
  state_t              state_q;
  logic [CNT_W-1:0]    len_q, i_q, k_q, len_d, i_d;
  logic [KEEP_W-1:0]   keep_q, run_q, keep_d, run_d;
  logic [DATA_W-1:0]   last_q;
  logic                err_q, acc, is_new, keep, we;
  always_comb begin
    len_d  = (len_i > DEPTH_C) ? DEPTH_C : len_i;
    keep_d = (keep_n_i == '0) ? KEEP_W'(1) : keep_n_i;
    acc    = (state_q == RUN) && in_if.valid;
    is_new = (i_q == '0) || (in_if.data != last_q);
    keep   = is_new || (run_q < keep_q);
    we     = acc && keep;
    run_d  = is_new ? KEEP_W'(1) : KEEP_W'(sat_inc(32'(run_q), RUN_MAX));
    i_d    = i_q + CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      keep_q  <= '0;
      i_q     <= '0;
      k_q     <= '0;
      run_q   <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else if (state_q != RUN && start_i) begin
      state_q <= (len_d == '0) ? DONE : RUN;
      len_q   <= len_d;
      keep_q  <= keep_d;
      i_q     <= '0;
      k_q     <= '0;
      run_q   <= '0;
      err_q   <= 1'b0;
    end else if (acc) begin
      i_q    <= i_d;
      run_q  <= run_d;
      last_q <= in_if.data;
      if (we) k_q <= k_q + CNT_W'(1);
      if (i_q != '0 && in_if.data < last_q) err_q <= 1'b1;
      if (i_d == len_q) state_q <= DONE;
    end
  end
  dedup_buf_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk (clk),
    .rst (rst),
    .we_i(we),
    .wa_i(k_q[AW-1:0]),
    .wd_i(in_if.data),
    .re_i(rd_addr_i < k_q),
    .ra_i(rd_addr_i[AW-1:0]),
    .rd_o(rd_data_o)
  );
  assign in_if.ready    = (state_q == RUN);
  assign busy_o         = (state_q == RUN);
  assign done_o         = (state_q == DONE);
  assign k_o            = k_q;
  assign err_unsorted_o = err_q;
endmodule

// File: tb/tb_sorted_dedup_stream.sv
// tb_sorted_dedup_stream: directed and random jobs checked against a windowed reference model.
module tb_sorted_dedup_stream;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int KEEP_W = 3;
  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  len;
  logic [KEEP_W-1:0] keep_n;
  logic [CNT_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy, done, err;
  logic [CNT_W-1:0]  k;
  int                n_tests = 0;
  int                n_fail = 0;
  logic [31:0]       stim [$];
  logic [31:0]       exp_buf [DEPTH];
  int                exp_k;
  bit                exp_err;
  sorted_dedup_stream_if #(.DATA_W(DATA_W)) in_if ();
  sorted_dedup_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .KEEP_W(KEEP_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .len_i         (len),
    .keep_n_i      (keep_n),
    .in_if         (in_if),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .busy_o        (busy),
    .done_o        (done),
    .k_o           (k),
    .err_unsorted_o(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // An element survives when fewer than keep_n equal elements directly precede it in the input.
  function automatic void model(input int n, input int kn);
    int ke, c;
    ke = (kn == 0) ? 1 : kn;
    exp_k = 0;
    exp_err = 0;
    for (int j = 0; j < n; j++) begin
      c = 0;
      while (j - 1 - c >= 0 && stim[j-1-c] == stim[j]) c++;
      if (c < ke) begin
        exp_buf[exp_k] = stim[j];
        exp_k++;
      end
      if (j > 0 && stim[j] < stim[j-1]) exp_err = 1;
    end
  endfunction
  task automatic do_start(input int ln, input int kn);
    @(negedge clk);
    start = 1'b1;
    len = CNT_W'(ln);
    keep_n = KEEP_W'(kn);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic feed(input int limit, input bit gaps, input bit mid, output int acc);
    int cyc;
    bit rdy;
    acc = 0;
    cyc = 0;
    while (acc < limit && !done && cyc < 400) begin
      in_if.valid = gaps ? (cyc % 2 == 0) : 1'b1;
      in_if.data = stim[acc];
      start = mid && (cyc == 2);
      len = '0;
      rdy = in_if.ready;
      @(posedge clk);
      if (in_if.valid && rdy) acc++;
      cyc++;
      @(negedge clk);
    end
    in_if.valid = 1'b0;
    start = 1'b0;
  endtask
  task automatic readback(input string tag);
    for (int a = 0; a <= DEPTH; a++) begin
      rd_addr = CNT_W'(a);
      @(posedge clk);
      @(negedge clk);
      check(tag, rd_data, (a < exp_k) ? exp_buf[a] : 32'd0);
    end
  endtask
  task automatic run_job(input string tag, input int ln, input int kn, input bit gaps, input bit mid);
    int lc, acc;
    lc = (ln > DEPTH) ? DEPTH : ln;
    do_start(ln, kn);
    check({tag, "_start_busy"}, 32'(busy), 32'(lc != 0));
    check({tag, "_start_done"}, 32'(done), 32'(lc == 0));
    check({tag, "_start_k"}, 32'(k), 32'd0);
    feed(stim.size(), gaps, mid, acc);
    model(lc, kn);
    check({tag, "_accepted"}, 32'(acc), 32'(lc));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(in_if.ready), 32'd0);
    check({tag, "_k"}, 32'(k), 32'(exp_k));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    readback({tag, "_rd"});
  endtask
  task automatic gen(input int n, input bit uns);
    logic [31:0] v;
    stim.delete();
    v = $urandom_range(0, 5);
    for (int j = 0; j < n; j++) begin
      if ($urandom_range(0, 2) == 0) v = v + $urandom_range(1, 3);
      if (uns && v > 0 && $urandom_range(0, 7) == 0) v = v - 1;
      stim.push_back(v);
    end
  endtask
  initial begin
    int acc;
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    keep_n = '0;
    rd_addr = '0;
    in_if.valid = 1'b0;
    in_if.data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_k", 32'(k), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(in_if.ready), 32'd0);
    check("rst_rd", rd_data, 32'd0);
    stim = '{0, 0, 1, 1, 1, 2, 2, 3, 3, 4};
    run_job("t1", 10, 1, 0, 0);
    check("t1_k_const", 32'(k), 32'd5);
    stim = '{1, 1, 1, 2, 2, 3};
    run_job("t2", 6, 2, 0, 0);
    check("t2_k_const", 32'(k), 32'd5);
    rd_addr = CNT_W'(7);
    @(posedge clk);
    @(negedge clk);
    check("t2_rd7", rd_data, 32'd0);
    stim.delete();
    run_job("t3_len0", 0, 1, 0, 0);
    gen(40, 0);
    run_job("t3_len40", 40, 1, 0, 0);
    stim = '{5, 5, 6};
    run_job("t4", 3, 0, 1, 1);
    check("t4_k_const", 32'(k), 32'd2);
    stim = '{3, 2, 2};
    run_job("t5", 3, 1, 0, 0);
    check("t5_err_const", 32'(err), 32'd1);
    stim = '{0, 0, 1, 1, 1, 2, 2, 3, 3, 4};
    run_job("t5_clr", 10, 1, 0, 0);
    check("t5_clr_err_const", 32'(err), 32'd0);
    gen(10, 0);
    do_start(10, 2);
    feed(3, 0, 0, acc);
    check("t6_pre_acc", 32'(acc), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_k", 32'(k), 32'd0);
    check("t6_ready", 32'(in_if.ready), 32'd0);
    rd_addr = '0;
    @(posedge clk);
    @(negedge clk);
    check("t6_rd", rd_data, 32'd0);
    stim = '{1, 1, 1, 2, 2, 3};
    run_job("t6_new", 6, 2, 0, 0);
    gen(12, 0);
    run_job("t6_b2b", 12, 3, 0, 0);
    for (int r = 0; r < 20; r++) begin
      int ln;
      ln = $urandom_range(0, 40);
      gen(ln, $urandom_range(0, 3) == 0);
      run_job("rnd", ln, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
